// File: rtl/morse_pkg.sv
// Shared Morse definitions: keyer states, code map constants, unit multiples
// and the lookup entry layout used by the keyer and any future detector.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_e;

  localparam logic [5:0] CODE_DIGIT0 = 6'd26;
  localparam logic [5:0] CODE_WSPACE = 6'd36;
  localparam logic [5:0] CODE_MAX    = 6'd36;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  // Pattern is right-aligned: the first element sits at bit len-1, 1 = dash.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pattern;
    logic       legal;
  } morse_entry_t;

  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ITU Morse lookup: character code to element count and pattern.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0]   char_code,
  output morse_entry_t entry
);

  logic [3:0] digit;

  // Digits follow a regular dot/dash ramp, so they are computed, not tabled.
  always_comb begin
    entry = '0;
    digit = 4'(char_code - CODE_DIGIT0);
    if (char_code > CODE_MAX) begin
      entry = '0;
    end else if (char_code == CODE_WSPACE) begin
      entry.legal = 1'b1;
    end else if (char_code >= CODE_DIGIT0) begin
      entry.len     = 3'd5;
      entry.pattern = (digit <= 4'd5) ? (5'b11111 >> digit)
                                      : ~(5'b11111 >> (digit - 4'd5));
      entry.legal   = 1'b1;
    end else begin
      entry.legal = 1'b1;
      case (char_code)
        6'd0:  {entry.len, entry.pattern} = 8'b010_00001;
        6'd1:  {entry.len, entry.pattern} = 8'b100_01000;
        6'd2:  {entry.len, entry.pattern} = 8'b100_01010;
        6'd3:  {entry.len, entry.pattern} = 8'b011_00100;
        6'd4:  {entry.len, entry.pattern} = 8'b001_00000;
        6'd5:  {entry.len, entry.pattern} = 8'b100_00010;
        6'd6:  {entry.len, entry.pattern} = 8'b011_00110;
        6'd7:  {entry.len, entry.pattern} = 8'b100_00000;
        6'd8:  {entry.len, entry.pattern} = 8'b010_00000;
        6'd9:  {entry.len, entry.pattern} = 8'b100_00111;
        6'd10: {entry.len, entry.pattern} = 8'b011_00101;
        6'd11: {entry.len, entry.pattern} = 8'b100_00100;
        6'd12: {entry.len, entry.pattern} = 8'b010_00011;
        6'd13: {entry.len, entry.pattern} = 8'b010_00010;
        6'd14: {entry.len, entry.pattern} = 8'b011_00111;
        6'd15: {entry.len, entry.pattern} = 8'b100_00110;
        6'd16: {entry.len, entry.pattern} = 8'b100_01101;
        6'd17: {entry.len, entry.pattern} = 8'b011_00010;
        6'd18: {entry.len, entry.pattern} = 8'b011_00000;
        6'd19: {entry.len, entry.pattern} = 8'b001_00001;
        6'd20: {entry.len, entry.pattern} = 8'b011_00001;
        6'd21: {entry.len, entry.pattern} = 8'b100_00001;
        6'd22: {entry.len, entry.pattern} = 8'b011_00011;
        6'd23: {entry.len, entry.pattern} = 8'b100_01001;
        6'd24: {entry.len, entry.pattern} = 8'b100_01011;
        6'd25: {entry.len, entry.pattern} = 8'b100_01100;
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse transmitter: accepts one character code over valid/ready and keys it
// out as dots, dashes and gaps timed in whole units of UNIT_CYCLES clocks.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25000000
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       key_out,
  output logic       char_done,
  output logic       code_err
);

  localparam logic [31:0] UNIT_LAST = 32'(UNIT_CYCLES - 1);

  state_e       state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [2:0]   units_q, units_d;
  logic [2:0]   elem_q, elem_d;
  logic [4:0]   pat_q, pat_d;
  logic         err_pend_q, err_pend_d;
  logic         key_out_q, key_out_d;
  logic         char_ready_q, char_ready_d;
  logic         char_done_q, char_done_d;
  logic         code_err_q, code_err_d;

  morse_entry_t rom_entry;
  logic         accept;
  logic         unit_end;
  logic         take_new;
  logic [4:0]   pat_shift;
  logic [4:0]   rom_shift;

  morse_rom u_rom (
    .char_code (char_code),
    .entry     (rom_entry)
  );

  assign accept    = char_valid && char_ready_q;
  assign unit_end  = (cnt_q == UNIT_LAST);
  assign pat_shift = pat_q >> (elem_q - 3'd1);
  assign rom_shift = rom_entry.pattern >> (rom_entry.len - 3'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    units_d     = units_q;
    elem_d      = elem_q;
    pat_d       = pat_q;
    err_pend_d  = err_pend_q;
    char_done_d = 1'b0;
    code_err_d  = 1'b0;
    take_new    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (err_pend_q) begin
          code_err_d = 1'b1;
          err_pend_d = 1'b0;
        end else if (accept) begin
          take_new = 1'b1;
        end
      end
      default: begin
        // units_q holds the whole units still to run after the current one
        if (!unit_end) begin
          cnt_d = cnt_q + 32'd1;
        end else if (units_q != 3'd0) begin
          cnt_d   = '0;
          units_d = units_q - 3'd1;
        end else begin
          cnt_d = '0;
          if (state_q == ST_MARK) begin
            elem_d = elem_q - 3'd1;
            if (elem_q == 3'd1) begin
              state_d = ST_CHAR_GAP;
              units_d = CHAR_GAP_UNITS - 3'd1;
            end else begin
              state_d = ST_ELEM_GAP;
              units_d = ELEM_GAP_UNITS - 3'd1;
            end
          end else if (state_q == ST_ELEM_GAP) begin
            state_d = ST_MARK;
            units_d = mark_units(pat_shift[0]) - 3'd1;
          end else begin
            state_d     = ST_IDLE;
            char_done_d = 1'b1;
            take_new    = accept;
          end
        end
      end
    endcase

    // A code taken on the closing edge of a gap starts with no idle bubble.
    if (take_new) begin
      cnt_d = '0;
      if (char_code == CODE_WSPACE) begin
        state_d = ST_WORD_GAP;
        units_d = WORD_GAP_UNITS - 3'd1;
      end else if (rom_entry.legal) begin
        state_d = ST_MARK;
        pat_d   = rom_entry.pattern;
        elem_d  = rom_entry.len;
        units_d = mark_units(rom_shift[0]) - 3'd1;
      end else begin
        state_d    = ST_IDLE;
        err_pend_d = 1'b1;
      end
    end

    key_out_d    = (state_d == ST_MARK);
    // Ready is raised for the final gap cycle so the next code lands exactly
    // on the edge that closes the gap.
    char_ready_d = ((state_d == ST_IDLE) && !err_pend_d) ||
                   (((state_d == ST_CHAR_GAP) || (state_d == ST_WORD_GAP)) &&
                    (units_d == 3'd0) && (cnt_d == UNIT_LAST));
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      units_q      <= '0;
      elem_q       <= '0;
      pat_q        <= '0;
      err_pend_q   <= 1'b0;
      key_out_q    <= 1'b0;
      char_ready_q <= 1'b1;
      char_done_q  <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      units_q      <= units_d;
      elem_q       <= elem_d;
      pat_q        <= pat_d;
      err_pend_q   <= err_pend_d;
      key_out_q    <= key_out_d;
      char_ready_q <= char_ready_d;
      char_done_q  <= char_done_d;
      code_err_q   <= code_err_d;
    end
  end

  assign char_ready = char_ready_q;
  assign key_out    = key_out_q;
  assign char_done  = char_done_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: expected output events are queued at
// accept time from an independent Morse table and matched as the DUT emits them.
module tb_morse_keyer;

  localparam int U = 4;
  localparam int DONE_EVT = 1;
  localparam int ERR_EVT  = 2;
  localparam int RISE_EVT = 3;
  localparam int FALL_EVT = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       charValid = 1'b0;
  logic [5:0] charCode = 6'd0;
  logic       charReady, keyOut, charDone, codeErr;
  logic       prevKey = 1'b0;

  int checks = 0;
  int failures = 0;
  int edgeNum = 0;
  int nextFree = 0;
  int expQ[$];

  string morseTbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
    "....", "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-",
    ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."};

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .in_clk     (clock),
    .rst        (rst),
    .char_valid (charValid),
    .char_code  (charCode),
    .char_ready (charReady),
    .key_out    (keyOut),
    .char_done  (charDone),
    .code_err   (codeErr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeNum <= edgeNum + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d (edge %0d)", tag, got, exp, edgeNum);
    end
  endtask

  // Events are encoded as edge*8 + kind so one comparison covers both.
  task automatic handleEvent(input int kind);
    int got;
    int exp;
    got = edgeNum * 8 + kind;
    if (expQ.size() == 0) begin
      checkOutput("evt_unexpected", got, 0);
    end else begin
      exp = expQ.pop_front();
      checkOutput("evt", got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (charDone) handleEvent(DONE_EVT);
    if (codeErr) handleEvent(ERR_EVT);
    if (keyOut && !prevKey) handleEvent(RISE_EVT);
    if (!keyOut && prevKey) handleEvent(FALL_EVT);
    prevKey = keyOut;
  end

  task automatic pushChar(input logic [5:0] code, input int acc);
    string s;
    int t;
    byte ch;
    if (code == 6'd36) begin
      expQ.push_back((acc + 7 * U) * 8 + DONE_EVT);
      nextFree = acc + 7 * U;
    end else if (code > 6'd36) begin
      expQ.push_back((acc + 1) * 8 + ERR_EVT);
      nextFree = acc + 2;
    end else begin
      s = morseTbl[code];
      t = acc;
      for (int i = 0; i < s.len(); i++) begin
        ch = s.getc(i);
        expQ.push_back(t * 8 + RISE_EVT);
        t += (ch == "-") ? 3 * U : U;
        expQ.push_back(t * 8 + FALL_EVT);
        if (i != s.len() - 1) t += U;
      end
      t += 3 * U;
      expQ.push_back(t * 8 + DONE_EVT);
      nextFree = t;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic applyStimulus(input logic [5:0] code, input bit hold);
    int expAcc;
    int acc;
    int waited;
    expAcc = (nextFree > edgeNum + 1) ? nextFree : edgeNum + 1;
    charCode = code;
    charValid = 1'b1;
    waited = 0;
    while (!charReady && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!charReady) begin
      checkOutput("accept_timeout", 0, 1);
      charValid = 1'b0;
    end else begin
      acc = edgeNum + 1;
      checkOutput("accept_edge", acc, expAcc);
      pushChar(code, acc);
      @(posedge clock);
      #1;
      if (!hold) charValid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (expQ.size() > 0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    repeat (3) @(negedge clock);
    checkOutput("drained", expQ.size(), 0);
  endtask

  initial begin
    int startAcc;
    int resetEdge;
    int w;
    int keep[$];
    logic [5:0] codes[6] = '{6'd10, 6'd36, 6'd63, 6'd25, 6'd35, 6'd18};

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_key_out", int'(keyOut), 0);
    checkOutput("rst_char_ready", int'(charReady), 1);
    checkOutput("rst_char_done", int'(charDone), 0);
    checkOutput("rst_code_err", int'(codeErr), 0);
    rst = 1'b0;
    nextFree = edgeNum + 1;

    applyStimulus(6'd4, 1'b0);
    waitDrain();
    applyStimulus(6'd0, 1'b0);
    waitDrain();
    applyStimulus(6'd26, 1'b0);
    waitDrain();

    applyStimulus(6'd19, 1'b1);
    applyStimulus(6'd19, 1'b0);
    waitDrain();

    applyStimulus(6'd36, 1'b0);
    waitDrain();
    applyStimulus(6'd50, 1'b0);
    waitDrain();

    applyStimulus(6'd0, 1'b0);
    startAcc = edgeNum;
    w = 0;
    while (edgeNum < startAcc + 5 && w < 50) begin
      @(negedge clock);
      w++;
    end
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    resetEdge = edgeNum;
    keep = {};
    foreach (expQ[i]) if (expQ[i] / 8 < resetEdge) keep.push_back(expQ[i]);
    expQ = keep;
    @(negedge clock);
    checkOutput("midrst_key_out", int'(keyOut), 0);
    checkOutput("midrst_char_ready", int'(charReady), 1);
    nextFree = resetEdge + 1;

    foreach (codes[i]) applyStimulus(codes[i], 1'b0);
    waitDrain();

    checkOutput("end_key_out", int'(keyOut), 0);
    checkOutput("end_char_ready", int'(charReady), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
